// File: rtl/wb_trace_buffer_pkg.sv
// Shared widths and the default trace entry layout for the writeback trace buffer.
// Ports: none (package).
package wb_trace_pkg;

    localparam int REG_W           = 5;
    localparam int DATA_W          = 32;
    localparam int DROP_W          = 16;
    localparam int CYCLE_W_DEFAULT = 16;

    // Default entry layout. Instances with a different CYCLE_W declare a
    // matching local struct and hand it to the FIFO as its entry type.
    typedef struct packed {
        logic [CYCLE_W_DEFAULT-1:0] cycle;
        logic [REG_W-1:0]           rd;
        logic [DATA_W-1:0]          data;
    } trace_entry_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Valid/ready trace stream carrying the head entry of the trace FIFO.
// master: the trace buffer (drives out_valid/out_cycle/out_reg/out_data, reads out_ready)
// slave : the drain (UART, debug port) that consumes entries.
interface wb_trace_buffer_if
    import wb_trace_pkg::*;
#(
    parameter int CYCLE_W = CYCLE_W_DEFAULT
);
    logic               out_valid;
    logic               out_ready;
    logic [CYCLE_W-1:0] out_cycle;
    logic [REG_W-1:0]   out_reg;
    logic [DATA_W-1:0]  out_data;

    modport master (output out_valid, out_cycle, out_reg, out_data, input out_ready);
    modport slave  (input out_valid, out_cycle, out_reg, out_data, output out_ready);
endinterface

// File: rtl/wb_trace_buffer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO of generic entries.
// Ports: clock, reset (async active-low), flush_i (sync clear), push_i/entry_i,
//        pop_i, head_o (entry at read pointer), full_o, empty_o, count_o.
// A push while full is accepted only when a pop happens on the same edge;
// a pop while empty is ignored.
module sync_fifo
    import wb_trace_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = trace_entry_t
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush_i,
    input  logic                 push_i,
    input  entry_t               entry_i,
    input  logic                 pop_i,
    output entry_t               head_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    entry_t             mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap for free.
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately left unreset; validity comes from count_q,
    // and a reset here would turn the array into flops with reset muxes.
    always_ff @(posedge clock) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: stamps every committed non-r0 register write with a
// free-running cycle count and queues it for a valid/ready drain.
// Ports: clock, reset (async active-low), enable (capture + counter enable),
//        clear (sync flush), ctrl_writeEnable/ctrl_writeReg/data_writeReg
//        (regfile write port), trace (stream master), count (occupancy),
//        overflow (sticky drop flag), drop_count (saturating drop counter).
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int CYCLE_W = CYCLE_W_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic                   ctrl_writeEnable,
    input  logic [REG_W-1:0]       ctrl_writeReg,
    input  logic [DATA_W-1:0]      data_writeReg,
    wb_trace_buffer_if.master      trace,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);
    typedef struct packed {
        logic [CYCLE_W-1:0] cycle;
        logic [REG_W-1:0]   rd;
        logic [DATA_W-1:0]  data;
    } entry_t;

    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic               overflow_q, overflow_d;
    logic [DROP_W-1:0]  drop_q, drop_d;
    logic               capture, push, pop, drop;
    logic               fifo_full, fifo_empty;
    entry_t             push_entry, head;

    assign capture    = enable & ctrl_writeEnable & (ctrl_writeReg != '0);
    assign push       = capture & ~clear;
    assign pop        = trace.out_valid & trace.out_ready;
    // Dropped only when full and no same-edge pop frees a slot.
    assign drop       = push & fifo_full & ~pop;
    assign push_entry = '{cycle: cycle_q, rd: ctrl_writeReg, data: data_writeReg};

    sync_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (clear),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count)
    );

    always_comb begin
        cycle_d    = cycle_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        if (clear) begin
            cycle_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            if (enable) cycle_d = cycle_q + CYCLE_W'(1);
            if (drop) begin
                overflow_d = 1'b1;
                drop_d     = sat_inc(drop_q);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    // Head fields are gated by validity so an empty or reset buffer shows zeros
    // rather than stale, unreset storage contents.
    assign trace.out_valid = ~fifo_empty;
    assign trace.out_cycle = fifo_empty ? '0 : head.cycle;
    assign trace.out_reg   = fifo_empty ? '0 : head.rd;
    assign trace.out_data  = fifo_empty ? '0 : head.data;
    assign overflow        = overflow_q;
    assign drop_count      = drop_q;

endmodule
